pu_riscv_if_fetch_seq: RTL and testbench
========================================

PU_RISCV_IF_FETCH_SEQ -- requirements
Module: pu_riscv_if_fetch_seq

Interface
REQ-001 Parameter XLEN, default 64, address and PC width.
REQ-002 Parameter PARCEL_SIZE, default 64, fetched parcel width; a multiple of 16.
REQ-003 Parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered bus requests; range 1..3.
REQ-004 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 Port rstn, input, 1, reset: asynchronous, active-low.
REQ-006 if_nxt_pc, input, XLEN: address the fetch stage requests next.
REQ-007 if_stall, input, 1: fetch stage cannot accept a parcel this cycle.
REQ-008 if_flush, input, 1: discard all in-flight fetches; restart at if_nxt_pc.
REQ-009 if_stall_nxt_pc, output, 1: fetch stage SHALL hold if_nxt_pc (request not issued this cycle).
REQ-010 mem_req, output, 1: bus request strobe.
REQ-011 mem_adr, output, XLEN: bus request address.
REQ-012 mem_ack, input, 1: request accepted in the current cycle.
REQ-013 mem_rvalid, input, 1: response data valid.
REQ-014 mem_rdata, input, PARCEL_SIZE: response data.
REQ-015 mem_err, input, 1: response carries an access fault.
REQ-016 if_parcel, output, PARCEL_SIZE: parcel to fetch stage.
REQ-017 if_parcel_pc, output, XLEN: address of if_parcel.
REQ-018 if_parcel_valid, output, PARCEL_SIZE/16: per-16-bit-slot valid.
REQ-019 if_parcel_misaligned, output, 1: if_parcel_pc[0] set.
REQ-020 if_parcel_page_fault, output, 1: mem_err was returned for this parcel.

Function
REQ-021 FSM states: IDLE (no request), FETCH (issuing/awaiting), DRAIN (discarding stale responses after flush).
REQ-022 IDLE->FETCH the first cycle after reset release; FETCH->DRAIN on if_flush with outstanding>0; DRAIN->FETCH when the discard counter reaches 0; if_flush with outstanding==0 stays in FETCH.
REQ-023 mem_req = state FETCH & ~if_flush & (outstanding<MAX_OUTSTANDING) & skid buffer empty-or-draining; mem_adr = if_nxt_pc, combinational.
REQ-024 if_stall_nxt_pc = ~(mem_req & mem_ack).
REQ-025 Each accepted request pushes its address into a MAX_OUTSTANDING-deep PC FIFO; each mem_rvalid pops it.
REQ-026 Outstanding counter +1 on accept, -1 on response, unchanged on both in the same cycle; never exceeds MAX_OUTSTANDING and never underflows.
REQ-027 On if_flush: discard counter <= outstanding (net of same-cycle accept/response), PC FIFO cleared, skid buffer cleared; responses arriving while discard counter>0 decrement it and SHALL NOT reach the outputs.
REQ-028 Non-discarded response, if_stall=0: outputs registered next cycle (latency 1), if_parcel_valid all ones.
REQ-029 Non-discarded response, if_stall=1: captured in a one-entry skid buffer; outputs hold previous parcel with valid=0; buffer presented the first cycle if_stall=0.
REQ-030 Skid buffer full blocks new requests (REQ-023) so no response is ever lost.
REQ-031 Valid held for exactly one cycle per parcel; if_parcel_valid=0 in every cycle without a fresh parcel.
REQ-032 if_flush in the same cycle as mem_rvalid: response discarded.
REQ-033 mem_rvalid with outstanding==0 is a protocol error: ignored; simulation assertion fires.

Reset
REQ-034 rstn low: state IDLE, counters 0, FIFO and skid buffer empty, mem_req=0, if_parcel=0, if_parcel_pc=0, if_parcel_valid=0, misaligned=0, page_fault=0.
REQ-035 Reset mid-transaction: all in-flight requests are forgotten; the bus is reset by the same rstn.

Structure
REQ-036 FSM state enum and MAX_OUTSTANDING default belong in pu_riscv_pkg.
REQ-037 The PC FIFO is a sub-module, pu_riscv_if_pc_fifo (parameter DEPTH, WIDTH; push/pop/clear/empty/full).

Verification
REQ-038 Reset release, if_nxt_pc=0x8000_0000, mem_ack=1, 1-cycle memory -> parcel pc 0x8000_0000 two cycles later, valid=4'b1111.
REQ-039 Two requests accepted (0x...00, 0x...08), if_flush before responses, new pc 0x200 -> both old responses dropped; first visible parcel pc 0x200.
REQ-040 if_stall=1 for 3 cycles while response arrives -> valid=0 throughout, mem_req=0 after skid fills, parcel delivered the cycle if_stall falls.
REQ-041 mem_ack=0 for 5 cycles -> if_stall_nxt_pc=1, mem_adr stable, outstanding stays 0.
REQ-042 mem_err=1 on response for pc 0x1000 -> page_fault=1, valid asserted, next parcel page_fault=0.
REQ-043 if_nxt_pc=0x1001 -> if_parcel_misaligned=1 on the returned parcel.

Source files
------------

// File: rtl/pu_riscv_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package pu_riscv_pkg;

  localparam int MAX_OUTSTANDING_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pu_riscv_if_pc_fifo.sv
// Small FIFO holding the addresses of accepted-but-unanswered fetch requests.
module pu_riscv_if_pc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pu_riscv_if_fetch_seq.sv
// Fetch request sequencer: issues bus requests, tracks them, drops stale
// responses after a flush and holds one response while the fetch stage stalls.
//   state    | meaning
//   ST_IDLE  | out of reset, no request issued yet
//   ST_FETCH | issuing requests / awaiting responses
//   ST_DRAIN | discarding responses of requests made before a flush
module pu_riscv_if_fetch_seq
  import pu_riscv_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int PARCEL_SIZE     = 64,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [XLEN-1:0]          if_nxt_pc,
  input  logic                     if_stall,
  input  logic                     if_flush,
  output logic                     if_stall_nxt_pc,
  output logic                     mem_req,
  output logic [XLEN-1:0]          mem_adr,
  input  logic                     mem_ack,
  input  logic                     mem_rvalid,
  input  logic [PARCEL_SIZE-1:0]   mem_rdata,
  input  logic                     mem_err,
  output logic [PARCEL_SIZE-1:0]   if_parcel,
  output logic [XLEN-1:0]          if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                     if_parcel_misaligned,
  output logic                     if_parcel_page_fault
);

  localparam int SLOTS = PARCEL_SIZE / 16;

  fetch_state_t           state;
  logic [1:0]             outstanding, outstanding_nxt;
  logic [1:0]             discard, discard_nxt;
  logic [1:0]             pending, flush_left;
  logic                   accept, rsp_any, rsp_live;
  logic                   fifo_empty, fifo_full;
  logic [XLEN-1:0]        fifo_pc;
  logic                   skid_valid, skid_err, skid_load;
  logic [PARCEL_SIZE-1:0] skid_data;
  logic [XLEN-1:0]        skid_pc;
  logic                   show, show_err;
  logic [PARCEL_SIZE-1:0] show_data;
  logic [XLEN-1:0]        show_pc;

  assign mem_req = (state == ST_FETCH) & ~if_flush & ~fifo_full &
                   (outstanding < 2'(MAX_OUTSTANDING)) & (~skid_valid | ~if_stall);
  assign mem_adr         = if_nxt_pc;
  assign accept          = mem_req & mem_ack;
  assign if_stall_nxt_pc = ~accept;

  assign rsp_any  = mem_rvalid & ((outstanding != '0) | (discard != '0));
  assign rsp_live = mem_rvalid & ~fifo_empty & (discard == '0) & ~if_flush;

  // No request is issued during a flush, so only the response side nets out.
  assign pending    = outstanding + discard;
  assign flush_left = pending - {1'b0, rsp_any};

  always_comb begin
    outstanding_nxt = outstanding;
    if (if_flush)                outstanding_nxt = '0;
    else if (accept & ~rsp_live) outstanding_nxt = outstanding + 2'd1;
    else if (~accept & rsp_live) outstanding_nxt = outstanding - 2'd1;

    discard_nxt = discard;
    if (if_flush)                          discard_nxt = flush_left;
    else if (mem_rvalid && discard != '0)  discard_nxt = discard - 2'd1;
  end

  // A response bypasses the skid only when nothing older is waiting in it.
  always_comb begin
    show      = 1'b0;
    show_data = mem_rdata;
    show_pc   = fifo_pc;
    show_err  = mem_err;
    if (!if_flush && !if_stall) begin
      if (skid_valid) begin
        show      = 1'b1;
        show_data = skid_data;
        show_pc   = skid_pc;
        show_err  = skid_err;
      end else if (rsp_live) begin
        show = 1'b1;
      end
    end
  end

  assign skid_load = rsp_live & (if_stall ^ skid_valid);

  pu_riscv_if_pc_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_pc_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (rsp_live),
    .clear (if_flush),
    .wdata (if_nxt_pc),
    .rdata (fifo_pc),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= ST_IDLE;
      outstanding          <= '0;
      discard              <= '0;
      skid_valid           <= 1'b0;
      skid_err             <= 1'b0;
      skid_data            <= '0;
      skid_pc              <= '0;
      if_parcel            <= '0;
      if_parcel_pc         <= '0;
      if_parcel_valid      <= '0;
      if_parcel_misaligned <= 1'b0;
      if_parcel_page_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: if (if_flush && discard_nxt != '0) state <= ST_DRAIN;
        ST_DRAIN: if (discard_nxt == '0) state <= ST_FETCH;
        default:  state <= ST_IDLE;
      endcase

      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;

      if (if_flush)                     skid_valid <= 1'b0;
      else if (skid_load)               skid_valid <= 1'b1;
      else if (skid_valid && !if_stall) skid_valid <= 1'b0;

      if (skid_load) begin
        skid_data <= mem_rdata;
        skid_pc   <= fifo_pc;
        skid_err  <= mem_err;
      end

      if (show) begin
        if_parcel            <= show_data;
        if_parcel_pc         <= show_pc;
        if_parcel_valid      <= {SLOTS{1'b1}};
        if_parcel_misaligned <= show_pc[0];
        if_parcel_page_fault <= show_err;
      end else begin
        if_parcel_valid <= '0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rstn)
                   !(mem_rvalid && outstanding == '0 && discard == '0))
    else $error("mem_rvalid with no request in flight");

endmodule

// File: tb/tb_pu_riscv_if_fetch_seq.sv
// Directed bench for the fetch sequencer; a negedge monitor checks every
// delivered parcel against a queue of hand-written expectations.
module tb_pu_riscv_if_fetch_seq;

  localparam int XLEN = 64;
  localparam int PS   = 64;
  localparam int NS   = PS / 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [XLEN-1:0] if_nxt_pc;
  logic            if_stall, if_flush;
  logic            if_stall_nxt_pc;
  logic            mem_req;
  logic [XLEN-1:0] mem_adr;
  logic            mem_ack, mem_rvalid, mem_err;
  logic [PS-1:0]   mem_rdata;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [NS-1:0]   if_parcel_valid;
  logic            if_parcel_misaligned, if_parcel_page_fault;

  always #5 clk = ~clk;

  pu_riscv_if_fetch_seq dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .mem_req              (mem_req),
    .mem_adr              (mem_adr),
    .mem_ack              (mem_ack),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .mem_err              (mem_err),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   data;
    logic            err;
    logic            mis;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_parcel(input logic [XLEN-1:0] pc, input logic [PS-1:0] data,
                               input logic err, input logic mis);
    exp_t x;
    x.pc = pc; x.data = data; x.err = err; x.mis = mis;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && if_parcel_valid != '0) begin
      check("parcel_valid_all", 64'(if_parcel_valid), 64'hF);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_parcel: got pc %h expected none", if_parcel_pc);
      end else begin
        e = sb.pop_front();
        check("parcel_pc", if_parcel_pc, e.pc);
        check("parcel_data", if_parcel, e.data);
        check("parcel_page_fault", 64'(if_parcel_page_fault), 64'(e.err));
        check("parcel_misaligned", 64'(if_parcel_misaligned), 64'(e.mis));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    if_nxt_pc = 64'h8000_0000; if_stall = 0; if_flush = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_stall_nxt_pc", 64'(if_stall_nxt_pc), 1);
    check("rst_parcel", if_parcel, 0);
    check("rst_parcel_pc", if_parcel_pc, 0);
    check("rst_valid", 64'(if_parcel_valid), 0);
    check("rst_misaligned", 64'(if_parcel_misaligned), 0);
    check("rst_page_fault", 64'(if_parcel_page_fault), 0);
    rstn = 1;
    check("idle_no_req", 64'(mem_req), 0);

    // First fetch after reset, 1-cycle memory.
    tick(); mem_ack = 1; #1;
    check("first_req", 64'(mem_req), 1);
    check("first_adr", mem_adr, 64'h8000_0000);
    check("first_stall_nxt_pc", 64'(if_stall_nxt_pc), 0);
    tick(); mem_ack = 0; if_nxt_pc = 64'h8000_0008;
    expect_parcel(64'h8000_0000, 64'h1111_2222_3333_4444, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444; #1;
    check("valid_before_latency", 64'(if_parcel_valid), 0);
    tick(); mem_rvalid = 0; #1;
    check("latency_valid", 64'(if_parcel_valid), 64'hF);
    tick(); #1;
    check("valid_one_cycle", 64'(if_parcel_valid), 0);

    // Two requests in flight, then flush: both responses must vanish.
    if_nxt_pc = 64'h100; mem_ack = 1;
    tick(); if_nxt_pc = 64'h108; #1;
    check("second_req", 64'(mem_req), 1);
    tick(); mem_ack = 0; if_nxt_pc = 64'h200; #1;
    check("max_outstanding_blocks", 64'(mem_req), 0);
    if_flush = 1;
    tick(); if_flush = 0; mem_rvalid = 1; mem_rdata = 64'hDEAD_0000_0000_0100; #1;
    check("drain_no_req", 64'(mem_req), 0);
    tick(); mem_rdata = 64'hDEAD_0000_0000_0108;
    tick(); mem_rvalid = 0; #1;
    check("req_after_drain", 64'(mem_req), 1);
    check("adr_after_drain", mem_adr, 64'h200);
    mem_ack = 1;
    tick(); mem_ack = 0;
    expect_parcel(64'h200, 64'hAAAA_0000_0000_0200, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'hAAAA_0000_0000_0200;
    tick(); mem_rvalid = 0;

    // Response arrives while the fetch stage stalls for three cycles.
    tick(); if_nxt_pc = 64'h300; mem_ack = 1;
    tick(); mem_ack = 0; if_nxt_pc = 64'h308; if_stall = 1;
    expect_parcel(64'h300, 64'h3333_0000_0000_0300, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'h3333_0000_0000_0300; #1;
    check("stall_valid_0", 64'(if_parcel_valid), 0);
    for (int i = 0; i < 2; i++) begin
      tick(); mem_rvalid = 0; #1;
      check("skid_full_blocks_req", 64'(mem_req), 0);
      check("stall_valid_n", 64'(if_parcel_valid), 0);
    end
    tick(); if_stall = 0; #1;
    check("skid_drain_allows_req", 64'(mem_req), 1);
    check("unstall_valid_0", 64'(if_parcel_valid), 0);
    tick(); #1;
    check("skid_delivered", 64'(if_parcel_valid), 64'hF);

    // Bus withholds ack for five cycles.
    if_nxt_pc = 64'h400;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("noack_stall_nxt_pc", 64'(if_stall_nxt_pc), 1);
      check("noack_adr_stable", mem_adr, 64'h400);
      check("noack_req_held", 64'(mem_req), 1);
    end
    mem_ack = 1;
    tick(); mem_ack = 0;
    expect_parcel(64'h400, 64'h4444_0000_0000_0400, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'h4444_0000_0000_0400;
    tick(); mem_rvalid = 0;

    // Access fault, then a clean parcel; accept and response overlap.
    tick(); if_nxt_pc = 64'h1000; mem_ack = 1;
    tick(); if_nxt_pc = 64'h1008;
    expect_parcel(64'h1000, 64'h5555_0000_0000_1000, 1, 0);
    mem_rvalid = 1; mem_err = 1; mem_rdata = 64'h5555_0000_0000_1000;
    tick(); mem_ack = 0;
    expect_parcel(64'h1008, 64'h6666_0000_0000_1008, 0, 0);
    mem_err = 0; mem_rdata = 64'h6666_0000_0000_1008;
    tick(); mem_rvalid = 0;

    // Odd address.
    tick(); if_nxt_pc = 64'h1001; mem_ack = 1;
    tick(); mem_ack = 0;
    expect_parcel(64'h1001, 64'h7777_0000_0000_1001, 0, 1);
    mem_rvalid = 1; mem_rdata = 64'h7777_0000_0000_1001;
    tick(); mem_rvalid = 0;

    // Flush coinciding with the only response: dropped, no drain needed.
    tick(); if_nxt_pc = 64'h500; mem_ack = 1;
    tick(); mem_ack = 0; if_nxt_pc = 64'h600; if_flush = 1;
    mem_rvalid = 1; mem_rdata = 64'hDEAD_0000_0000_0500;
    tick(); if_flush = 0; mem_rvalid = 0; #1;
    check("flush_rsp_stays_fetch", 64'(mem_req), 1);
    mem_ack = 1;
    tick(); mem_ack = 0;
    expect_parcel(64'h600, 64'h8888_0000_0000_0600, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'h8888_0000_0000_0600;
    tick(); mem_rvalid = 0;

    // Reset with a request in flight: it is forgotten.
    tick(); if_nxt_pc = 64'h700; mem_ack = 1;
    tick(); mem_ack = 0; rstn = 0; #1;
    check("midrst_req", 64'(mem_req), 0);
    check("midrst_valid", 64'(if_parcel_valid), 0);
    tick(); rstn = 1; if_nxt_pc = 64'h800; #1;
    check("midrst_idle_no_req", 64'(mem_req), 0);
    tick(); #1;
    check("midrst_fetch_req", 64'(mem_req), 1);
    mem_ack = 1;
    tick(); mem_ack = 0;
    expect_parcel(64'h800, 64'h9999_0000_0000_0800, 0, 0);
    mem_rvalid = 1; mem_rdata = 64'h9999_0000_0000_0800;
    tick(); mem_rvalid = 0;

    repeat (3) tick();
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
